// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter used as a store/load responder.
// The core writes bytes into a TX FIFO. The FSM sends them on tx_o as 8N1, LSB first.
//
// Ports:
//   clk_i    system clock, all logic on the rising edge
//   rst_i    synchronous reset, active-high
//   sel_i    peripheral selected by the core's address decode
//   we_i     store strobe (qualified by sel_i)
//   re_i     load strobe (qualified by sel_i)
//   addr_i   byte offset: 0x0 TXDATA, 0x4 STATUS, other offsets reserved
//   wdata_i  store data
//   rdata_o  load data, registered (1-cycle latency)
//   tx_o     serial line, idle high
//   irq_o    high while the FIFO is empty and the transmitter is idle
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sel_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        idx_q;
    logic [7:0]        shift_q;
    logic              tx_q;

    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic              overflow_q;
    logic [31:0]       rdata_q;

    logic fifo_empty, fifo_full, tx_busy, stop_done;
    logic push_req, push, pop, drop, ovf_clr;
    logic [7:0] pop_data;
    logic [31:0] status;
    logic unused_wdata;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CountFull);
        tx_busy    = (state_q != StIdle);
        stop_done  = (state_q == StStop) && (cnt_q == CntLast);
        // Pop from IDLE, or on the last stop-bit cycle to chain frames without a gap.
        pop        = !fifo_empty && ((state_q == StIdle) || stop_done);
        push_req   = sel_i && we_i && (addr_i == 4'h0);
        // A full FIFO still accepts a byte when an entry leaves on the same edge.
        push       = push_req && (!fifo_full || pop);
        drop       = push_req && !push;
        ovf_clr    = sel_i && we_i && (addr_i == 4'h4) && wdata_i[3];
        pop_data   = fifo_q[rd_ptr_q];
        status     = {28'b0, overflow_q, tx_busy, fifo_empty, fifo_full};
    end

    assign unused_wdata = ^wdata_i[31:8];

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A drop on the same edge as a clear leaves the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
            if (sel_i && re_i) begin
                rdata_q <= (addr_i == 4'h4) ? status : 32'h0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= pop_data;
                        cnt_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == CntLast) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                            idx_q   <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == CntLast) begin
                        cnt_q <= '0;
                        if (pop) begin
                            shift_q <= pop_data;
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rdata_o = rdata_q;
    assign tx_o    = tx_q;
    assign irq_o   = fifo_empty && !tx_busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    mmio_uart_tx #(
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .sel_i   (sel),
        .we_i    (we),
        .re_i    (re),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .tx_o    (tx),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d);
        sel = 1'b1; re = 1'b1; addr = a;
        tick();
        sel = 1'b0; re = 1'b0;
        d = rdata;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Samples the current cycle first; returns positioned one cycle after the frame.
    task automatic check_frame(input logic [7:0] b);
        logic exp_bit;
        logic ok;
        logic bad;
        for (int k = 0; k < 10; k++) begin
            exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            ok  = 1'b1;
            bad = exp_bit;
            for (int c = 0; c < 16; c++) begin
                if (tx !== exp_bit) begin
                    ok  = 1'b0;
                    bad = tx;
                end
                tick();
            end
            chk($sformatf("frame_%h_bit%0d", b, k), {31'b0, bad}, {31'b0, exp_bit});
        end
    endtask

    logic [31:0] rd;

    initial begin
        rst = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;

        // T1 reset
        tick();
        tick();
        rst = 1'b0;
        chk("reset_tx", {31'b0, tx}, 32'h1);
        chk("reset_irq", {31'b0, irq}, 32'h1);
        chk("reset_rdata", rdata, 32'h0);
        do_read(4'h4, rd);
        chk("reset_status", rd, 32'h2);
        tick();
        chk("rdata_hold", rdata, 32'h2);
        do_read(4'h0, rd);
        chk("read_txdata_zero", rd, 32'h0);

        // T2 single byte
        do_write(4'h0, 32'h55);
        chk("t2_tx_before_start", {31'b0, tx}, 32'h1);
        chk("t2_irq_pending", {31'b0, irq}, 32'h0);
        tick();
        check_frame(8'h55);
        chk("t2_irq_after", {31'b0, irq}, 32'h1);
        chk("t2_tx_idle", {31'b0, tx}, 32'h1);

        // T3 back-to-back writes on consecutive cycles
        sel = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'hA5;
        tick();
        wdata = 32'h3C;
        tick();
        sel = 1'b0; we = 1'b0;
        check_frame(8'hA5);
        check_frame(8'h3C);
        chk("t3_irq_after", {31'b0, irq}, 32'h1);

        // T4 overflow while stalled in START
        sel = 1'b1; we = 1'b1; addr = 4'h0;
        for (int i = 0; i < 10; i++) begin
            wdata = 32'h30 + i;
            tick();
        end
        sel = 1'b0; we = 1'b0;
        do_read(4'h4, rd);
        chk("t4_status_ovf", rd, 32'hD);
        do_write(4'h4, 32'h8);
        do_read(4'h4, rd);
        chk("t4_status_cleared", rd, 32'h5);
        wait_cycles(149);
        for (int i = 1; i <= 8; i++) check_frame(8'h30 + 8'(i));
        chk("t4_irq_after", {31'b0, irq}, 32'h1);
        chk("t4_tx_idle", {31'b0, tx}, 32'h1);

        // T5 push into a full FIFO on the edge where the FSM pops
        sel = 1'b1; we = 1'b1; addr = 4'h0;
        for (int i = 0; i < 9; i++) begin
            wdata = 32'h40 + i;
            tick();
        end
        sel = 1'b0; we = 1'b0;
        wait_cycles(152);
        do_write(4'h0, 32'h49);
        for (int i = 1; i <= 9; i++) check_frame(8'h40 + 8'(i));
        chk("t5_irq_after", {31'b0, irq}, 32'h1);
        do_read(4'h4, rd);
        chk("t5_status_no_ovf", rd, 32'h2);

        // T6 reset during DATA bit 3
        do_write(4'h0, 32'hF0);
        wait_cycles(70);
        chk("t6_tx_bit3", {31'b0, tx}, 32'h0);
        chk("t6_busy_irq", {31'b0, irq}, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_tx_after_reset", {31'b0, tx}, 32'h1);
        chk("t6_irq_after_reset", {31'b0, irq}, 32'h1);
        chk("t6_rdata_after_reset", rdata, 32'h0);
        do_read(4'h4, rd);
        chk("t6_status", rd, 32'h2);
        do_write(4'h8, 32'hFF);
        chk("reserved_write_no_push", {31'b0, irq}, 32'h1);
        tick();
        chk("reserved_write_tx", {31'b0, tx}, 32'h1);
        do_write(4'h0, 32'h81);
        tick();
        check_frame(8'h81);
        chk("t6_irq_final", {31'b0, irq}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
